// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path: receiver state encoding,
// frame geometry and the default inter-edge timeout.
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Payload width and total bits on the wire (start + data + parity + stop).
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 11;

    // Index of the final data bit, compared against the receiver bit counter.
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_W - 1);

    // Peripheral-clock ticks tolerated between device-clock falling edges.
    localparam logic [15:0] RX_TIMEOUT_DEFAULT = 16'd2000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// -----------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for an asynchronous line, followed by a history flop
// so that single-cycle rise/fall pulses can be derived in the clock domain.
//
// Ports
//   clock     in   system clock
//   reset     in   synchronous, active-high reset
//   async_in  in   asynchronous input line
//   level     out  synchronized level of async_in
//   rise      out  one-cycle pulse on a synchronized 0->1 transition
//   fall      out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    // All flops reset to the idle-bus level (high) so that leaving reset never
    // looks like a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            meta_p0 <= async_in;
            // stage p0 -> p1: second synchronizer flop
            sync_p1 <= meta_p0;
            // stage p1 -> p2: previous synchronized value for edge detection
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;
    assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/ps2_receive_data.sv
// -----------------------------------------------------------------------------
// ps2_receive_data
// PS/2 device-to-host receiver. Samples start, eight data bits (LSB first),
// odd parity and stop on synchronized device-clock falling edges, checks the
// frame and hands good bytes to a consumer through a valid/ack handshake.
//
// Parameters
//   RX_TIMEOUT       peripheral_clock rising edges allowed between device-clock
//                    falling edges mid-frame before the frame is aborted
//
// Ports
//   clock            in   system clock (only clock domain)
//   reset            in   synchronous, active-high reset
//   peripheral_clock in   slow timebase, rising edges drive the timeout
//   device_clock     in   PS/2 clock line (asynchronous)
//   device_data      in   PS/2 data line (asynchronous)
//   inhibit          in   host transmitter owns the bus; receiver held idle
//   data_valid       out  recv_data holds an unconsumed byte
//   recv_data        out  last good byte
//   data_ack         in   consumer pulse releasing data_valid
//   parity_error     out  one-cycle pulse: frame dropped for bad parity
//   framing_error    out  one-cycle pulse: bad stop bit or timeout
//   overrun_error    out  sticky: good frame lost while data_valid was high
//   receiving_flag   out  receiver is inside a frame
// -----------------------------------------------------------------------------
module ps2_receive_data
    import ps2_pkg::*;
#(
    parameter logic [15:0] RX_TIMEOUT = RX_TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              peripheral_clock,
    input  logic              device_clock,
    input  logic              device_data,
    input  logic              inhibit,
    output logic              data_valid,
    output logic [DATA_W-1:0] recv_data,
    input  logic              data_ack,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun_error,
    output logic              receiving_flag
);

    // Odd parity holds when the data bits plus the parity bit contain an odd
    // number of ones.
    function automatic logic parity_ok(input logic [DATA_W-1:0] data,
                                       input logic              par);
        return ^{data, par};
    endfunction

    logic dclk_fall;
    logic ddat_level;
    logic pclk_rise;

    logic dclk_level_unused;
    logic dclk_rise_unused;
    logic ddat_rise_unused;
    logic ddat_fall_unused;
    logic pclk_level_unused;
    logic pclk_fall_unused;

    ps2_sync_edge u_sync_dclk (
        .clock    (clock),
        .reset    (reset),
        .async_in (device_clock),
        .level    (dclk_level_unused),
        .rise     (dclk_rise_unused),
        .fall     (dclk_fall)
    );

    ps2_sync_edge u_sync_ddat (
        .clock    (clock),
        .reset    (reset),
        .async_in (device_data),
        .level    (ddat_level),
        .rise     (ddat_rise_unused),
        .fall     (ddat_fall_unused)
    );

    ps2_sync_edge u_sync_pclk (
        .clock    (clock),
        .reset    (reset),
        .async_in (peripheral_clock),
        .level    (pclk_level_unused),
        .rise     (pclk_rise),
        .fall     (pclk_fall_unused)
    );

    ps2_rx_state_t     state;
    logic [3:0]        bit_count;
    logic [15:0]       timeout_count;
    logic [DATA_W-1:0] shift_data;
    logic              parity_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            bit_count     <= 4'd0;
            timeout_count <= 16'd0;
            data_valid    <= 1'b0;
            recv_data     <= '0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            parity_error  <= 1'b0;
            framing_error <= 1'b0;

            // Consumer handshake runs independently of the frame logic; a good
            // frame completing in the same cycle overrides the clear below.
            if (data_ack && data_valid) begin
                data_valid    <= 1'b0;
                overrun_error <= 1'b0;
            end

            if (inhibit) begin
                // Host owns the bus: drop any partial frame silently.
                state         <= IDLE;
                bit_count     <= 4'd0;
                timeout_count <= 16'd0;
            end else if (dclk_fall) begin
                timeout_count <= 16'd0;
                case (state)
                    IDLE: begin
                        // A high data line on a falling edge is a glitch, not
                        // a start bit.
                        if (!ddat_level) begin
                            state     <= DATA;
                            bit_count <= 4'd0;
                        end
                    end
                    DATA: begin
                        shift_data[bit_count[2:0]] <= ddat_level;
                        bit_count                  <= bit_count + 4'd1;
                        if (bit_count == LAST_DATA_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= ddat_level;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!ddat_level) begin
                            framing_error <= 1'b1;
                        end else if (!parity_ok(shift_data, parity_bit)) begin
                            parity_error <= 1'b1;
                        end else if (!data_valid || data_ack) begin
                            recv_data  <= shift_data;
                            data_valid <= 1'b1;
                        end else begin
                            overrun_error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (timeout_count == RX_TIMEOUT) begin
                    state         <= IDLE;
                    bit_count     <= 4'd0;
                    timeout_count <= 16'd0;
                    framing_error <= 1'b1;
                end else if (pclk_rise) begin
                    timeout_count <= timeout_count + 16'd1;
                end
            end
        end
    end

    assign receiving_flag = (state != IDLE);

endmodule

// File: doc/ps2_receive_data.md
PS2_RECEIVE_DATA -- requirements
Module: ps2_receive_data

Interface
REQ-001 Parameter RX_TIMEOUT, default 16'd2000: peripheral_clock rising edges allowed between device_clock falling edges mid-frame before abort.
REQ-002 clock  in  1  system clock; the only clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 peripheral_clock  in  1  slow timebase; only its rising edges, detected in the clock domain, are used.
REQ-005 device_clock  in  1  PS/2 clock line, asynchronous.
REQ-006 device_data  in  1  PS/2 data line, asynchronous.
REQ-007 inhibit  in  1  high while the host transmitter owns the bus; driven from its sending_data_flag.
REQ-008 data_valid  out  1  received byte is held on recv_data.
REQ-009 recv_data  out  8  last good byte.
REQ-010 data_ack  in  1  consumer pulse that releases data_valid.
REQ-011 parity_error  out  1  one-cycle pulse: frame dropped for bad parity.
REQ-012 framing_error  out  1  one-cycle pulse: frame dropped for bad stop bit or timeout.
REQ-013 overrun_error  out  1  sticky flag: a good frame was lost because data_valid was high.
REQ-014 receiving_flag  out  1  high whenever state != IDLE.

Function
REQ-015 device_clock, device_data and peripheral_clock SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized values.
REQ-016 Frame format: start 0, D0..D7 (LSB first), odd parity, stop 1; each bit is sampled on a synchronized device_clock falling edge.
REQ-017 States: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: on a falling edge, data 0 -> DATA with bit count 0; data 1 -> stay IDLE, no error (glitch).
REQ-019 DATA: each falling edge shifts data into bit[count] and increments count; after the 8th bit -> PARITY.
REQ-020 PARITY: the falling edge captures the parity bit -> STOP.
REQ-021 STOP: the falling edge -> IDLE, and the frame is evaluated.
REQ-022 Evaluation order: stop bit 0 -> framing_error; otherwise ones(D7..D0, parity) even -> parity_error; otherwise the frame is good.
REQ-023 Good frame with data_valid low, or with data_ack in the same cycle: recv_data is loaded and data_valid=1 in the next cycle (1-cycle latency after the stop edge).
REQ-024 Good frame with data_valid high and no data_ack: recv_data is unchanged, the frame is dropped, and overrun_error is set.
REQ-025 data_ack with data_valid high clears data_valid and overrun_error in the next cycle; data_ack with data_valid low has no effect.
REQ-026 Timeout counter: cleared on every falling edge and on entry to IDLE; increments on each peripheral_clock rising edge while state != IDLE.
REQ-027 When the counter equals RX_TIMEOUT: -> IDLE, framing_error pulse, partial data discarded.
REQ-028 inhibit high: state is forced to IDLE, the counter is cleared, edges are ignored, and no error is raised; data_valid and recv_data are unaffected.
REQ-029 Simultaneous inhibit and stop edge: inhibit wins and the frame is discarded.
REQ-030 recv_data SHALL change only when a good frame is accepted.

Reset
REQ-031 Reset SHALL set state=IDLE, count=0, timeout=0, data_valid=0, recv_data=8'h00, parity_error=0, framing_error=0, overrun_error=0, receiving_flag=0.
REQ-032 Synchronizers reset to 1 (bus idle), so releasing reset SHALL NOT produce a false falling edge.
REQ-033 Reset mid-frame SHALL discard the frame with no error pulse.

Structure
REQ-034 Package ps2_pkg holds the state enum ps2_rx_state_t, frame constants (8 data bits, 11 bits per frame), and the default RX_TIMEOUT.
REQ-035 One sub-module, ps2_sync_edge: 2-flop synchronizer with rise/fall pulses, instantiated three times.

Verification
REQ-036 Frame 0x1C with parity 0, stop 1 -> data_valid=1, recv_data=8'h1C, no error pulses; data_ack -> data_valid=0.
REQ-037 Frame 0xF0 with parity 0 (bad) -> one parity_error pulse, data_valid stays 0, recv_data unchanged.
REQ-038 Frame 0x00 with parity 1 and stop 0 -> one framing_error pulse, no data_valid.
REQ-039 Frame 0x1C left un-acked, then frame 0x32 (parity 0) -> recv_data stays 8'h1C and overrun_error=1; data_ack clears both data_valid and overrun_error.
REQ-040 Send start bit plus 3 bits, then hold the clock high for RX_TIMEOUT peripheral ticks -> one framing_error pulse, receiving_flag=0; a following 0x1C frame is received correctly.
REQ-041 inhibit=1 during a full 0x1C frame -> no data_valid and no errors; reset asserted mid-frame -> all outputs return to their reset values.
